// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle sequencer: widths, opcode values,
// FSM state encoding and the opcode classifier.
package cpu_pkg;

  localparam int PC_W_DEF        = 6;
  localparam int INSTR_W_DEF     = 32;
  localparam int MEM_TIMEOUT_DEF = 15;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;

  localparam logic [3:0] OP_ALU_MAX = 4'h7;
  localparam logic [3:0] OP_LOAD    = 4'h8;
  localparam logic [3:0] OP_STORE   = 4'h9;
  localparam logic [3:0] OP_JMP     = 4'hA;
  localparam logic [3:0] OP_BEQZ    = 4'hB;
  localparam logic [3:0] OP_NOP     = 4'hE;
  localparam logic [3:0] OP_HALT    = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_STOP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_JMP     = 3'd3,
    CLS_BEQZ    = 3'd4,
    CLS_NOP     = 3'd5,
    CLS_HALT    = 3'd6,
    CLS_ILLEGAL = 3'd7
  } op_class_e;

  function automatic op_class_e decode_op(input logic [3:0] op);
    op_class_e cls;
    if (op <= OP_ALU_MAX) begin
      cls = CLS_ALU;
    end else begin
      case (op)
        OP_LOAD:  cls = CLS_LOAD;
        OP_STORE: cls = CLS_STORE;
        OP_JMP:   cls = CLS_JMP;
        OP_BEQZ:  cls = CLS_BEQZ;
        OP_NOP:   cls = CLS_NOP;
        OP_HALT:  cls = CLS_HALT;
        default:  cls = CLS_ILLEGAL;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/seq_mem_timer.sv
// Data-memory wait counter: loaded to 1 on MEM entry, counts MEM cycles and
// flags the cycle in which the count has reached TIMEOUT.
module seq_mem_timer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_timeout
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  // Counter saturates at the limit so it never wraps back under it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_ONE;
    end else if (i_en && (r_cnt != CNT_LIM)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_timeout = i_en && (r_cnt == CNT_LIM);

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle control sequencer: owns pc and ir and steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, driving ALU, register file and dmem.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int INSTR_W     = INSTR_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  output logic [PC_W-1:0]    o_instr_addr,
  input  logic [INSTR_W-1:0] i_instr_data,
  output logic [INSTR_W-1:0] o_ir,
  output logic               o_alu_en,
  output logic [3:0]         o_alu_op,
  input  logic               i_alu_zero,
  output logic               o_rf_we,
  output logic               o_rf_wsel,
  output logic               o_dmem_req,
  output logic               o_dmem_we,
  input  logic               i_dmem_ack,
  output logic               o_busy,
  output logic               o_halted,
  output logic               o_fault
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_e             r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic               r_halted;
  logic               r_fault;

  state_e             w_state_nxt;
  logic [PC_W-1:0]    w_pc_nxt;
  logic               w_halted_nxt;
  logic               w_fault_nxt;
  logic               w_timer_load;
  logic               w_timeout;
  logic               w_in_mem;
  op_class_e          w_cls;
  logic [PC_W-1:0]    w_target;
  logic [PC_W-1:0]    w_pc_inc;

  assign w_cls    = decode_op(r_ir[OPC_HI:OPC_LO]);
  assign w_target = r_ir[PC_W-1:0];
  assign w_pc_inc = r_pc + PC_ONE;
  assign w_in_mem = (r_state == S_MEM);

  seq_mem_timer #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_mem_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_timer_load),
    .i_en      (w_in_mem),
    .o_timeout (w_timeout)
  );

  // State, pc and sticky status registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_halted <= w_halted_nxt;
      r_fault  <= w_fault_nxt;
    end
  end

  // Instruction register captures imem read data at the end of FETCH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ir <= '0;
    end else if (r_state == S_FETCH) begin
      r_ir <= i_instr_data;
    end else begin
      r_ir <= r_ir;
    end
  end

  // Next-state, pc update and status-flag logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_halted_nxt = r_halted;
    w_fault_nxt  = r_fault;
    w_timer_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt  = S_FETCH;
          w_halted_nxt = 1'b0;
        end else begin
          w_state_nxt  = S_IDLE;
        end
      end
      S_FETCH: w_state_nxt = S_DECODE;
      S_DECODE: begin
        case (w_cls)
          CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BEQZ: w_state_nxt = S_EXEC;
          CLS_JMP: begin
            w_pc_nxt    = w_target;
            w_state_nxt = S_FETCH;
          end
          CLS_NOP: begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_FETCH;
          end
          CLS_HALT: begin
            w_pc_nxt     = w_pc_inc;
            w_halted_nxt = 1'b1;
            w_state_nxt  = S_IDLE;
          end
          default: begin
            w_fault_nxt = 1'b1;
            w_state_nxt = S_STOP;
          end
        endcase
      end
      S_EXEC: begin
        if ((w_cls == CLS_LOAD) || (w_cls == CLS_STORE)) begin
          w_timer_load = 1'b1;
          w_state_nxt  = S_MEM;
        end else begin
          w_state_nxt  = S_WB;
        end
      end
      S_MEM: begin
        // An ack arriving in the timeout cycle still completes the access.
        if (i_dmem_ack) begin
          if (w_cls == CLS_STORE) begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_WB;
          end
        end else if (w_timeout) begin
          w_fault_nxt = 1'b1;
          w_state_nxt = S_STOP;
        end else begin
          w_state_nxt = S_MEM;
        end
      end
      S_WB: begin
        if ((w_cls == CLS_BEQZ) && i_alu_zero) begin
          w_pc_nxt = w_target;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
        w_state_nxt = S_FETCH;
      end
      S_STOP:  w_state_nxt = S_STOP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_instr_addr = r_pc;
  assign o_ir         = r_ir;
  assign o_alu_en     = (r_state == S_EXEC);
  assign o_alu_op     = o_alu_en ? r_ir[OPC_HI:OPC_LO] : 4'h0;
  assign o_rf_we      = (r_state == S_WB) && (w_cls != CLS_BEQZ);
  assign o_rf_wsel    = (r_state == S_WB) && (w_cls == CLS_LOAD);
  assign o_dmem_req   = w_in_mem;
  assign o_dmem_we    = w_in_mem && (w_cls == CLS_STORE);
  assign o_busy       = (r_state != S_IDLE);
  assign o_halted     = r_halted;
  assign o_fault      = r_fault;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench: an instruction-level model expands each instruction into
// its expected per-cycle outputs and inputs; directed and random programs.
module tb_cpu_sequencer;

  localparam int PC_W = 6;
  localparam int INSTR_W = 32;
  localparam int MEM_TIMEOUT = 15;
  localparam logic [31:0] NOP = 32'hE000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic alu_zero = 1'b0;
  logic dmem_ack = 1'b0;
  logic [PC_W-1:0] instr_addr;
  logic [INSTR_W-1:0] instr_data, ir;
  logic alu_en, rf_we, rf_wsel, dmem_req, dmem_we, busy, halted, fault;
  logic [3:0] alu_op;
  logic [31:0] imem [64];

  int n_checks = 0;
  int n_fail = 0;
  int req_cnt = 0;
  int rfwe_cnt = 0;

  cpu_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_instr_addr(instr_addr), .i_instr_data(instr_data), .o_ir(ir),
    .o_alu_en(alu_en), .o_alu_op(alu_op), .i_alu_zero(alu_zero),
    .o_rf_we(rf_we), .o_rf_wsel(rf_wsel), .o_dmem_req(dmem_req),
    .o_dmem_we(dmem_we), .i_dmem_ack(dmem_ack), .o_busy(busy),
    .o_halted(halted), .o_fault(fault)
  );

  assign instr_data = imem[instr_addr];

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] ir;
    logic        alu_en;
    logic [3:0]  alu_op;
    logic        rf_we, rf_wsel, req, we, busy, halted, fault;
    logic        start_v, zero_v, ack_v;
  } ent_t;

  ent_t q[$];

  logic [5:0]  m_pc;
  logic [31:0] m_ir;
  bit m_halted, m_fault, m_idle, m_stop;
  bit force_start;
  int force_lat;
  int force_zero;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic bit rb();
    return ($urandom & 32'd1) == 32'd1;
  endfunction

  task automatic push(input bit ae, input bit wr, input bit ws, input bit rq,
                      input bit dw, input bit bz, input bit st, input bit z, input bit ak);
    ent_t e;
    e.addr = m_pc; e.ir = m_ir; e.alu_en = ae;
    e.alu_op = ae ? m_ir[31:28] : 4'h0;
    e.rf_we = wr; e.rf_wsel = ws; e.req = rq; e.we = dw; e.busy = bz;
    e.halted = m_halted; e.fault = m_fault;
    e.start_v = st; e.zero_v = z; e.ack_v = ak;
    q.push_back(e);
  endtask

  // Expand one instruction (or one idle/stop cycle) into expected cycles.
  task automatic gen();
    logic [3:0] op;
    logic [5:0] tgt;
    bit st, z, acked, ak;
    int lat;
    if (m_stop) begin
      push(0, 0, 0, 0, 0, 1, rb(), rb(), rb());
    end else if (m_idle) begin
      st = force_start ? 1'b1 : ($urandom_range(0, 3) != 0);
      push(0, 0, 0, 0, 0, 0, st, rb(), rb());
      if (st) begin m_idle = 0; m_halted = 0; end
    end else begin
      push(0, 0, 0, 0, 0, 1, rb(), rb(), rb());
      m_ir = imem[m_pc];
      op = m_ir[31:28];
      tgt = m_ir[5:0];
      push(0, 0, 0, 0, 0, 1, rb(), rb(), rb());
      if (op <= 4'h7) begin
        push(1, 0, 0, 0, 0, 1, rb(), rb(), rb());
        push(0, 1, 0, 0, 0, 1, rb(), rb(), rb());
        m_pc = m_pc + 6'd1;
      end else if (op == 4'h8 || op == 4'h9) begin
        push(1, 0, 0, 0, 0, 1, rb(), rb(), rb());
        lat = (force_lat != 0) ? force_lat : $urandom_range(1, 16);
        acked = 0;
        for (int k = 1; k <= MEM_TIMEOUT; k++) begin
          ak = (k == lat);
          push(0, 0, 0, 1, op == 4'h9, 1, rb(), rb(), ak);
          if (ak) begin acked = 1; break; end
        end
        if (!acked) begin
          m_fault = 1; m_stop = 1;
        end else if (op == 4'h8) begin
          push(0, 1, 1, 0, 0, 1, rb(), rb(), rb());
          m_pc = m_pc + 6'd1;
        end else begin
          m_pc = m_pc + 6'd1;
        end
      end else if (op == 4'hA) begin
        m_pc = tgt;
      end else if (op == 4'hE) begin
        m_pc = m_pc + 6'd1;
      end else if (op == 4'hF) begin
        m_halted = 1; m_idle = 1;
        m_pc = m_pc + 6'd1;
      end else if (op == 4'hB) begin
        push(1, 0, 0, 0, 0, 1, rb(), rb(), rb());
        z = (force_zero >= 0) ? (force_zero != 0) : rb();
        push(0, 0, 0, 0, 0, 1, rb(), z, rb());
        m_pc = z ? tgt : m_pc + 6'd1;
      end else begin
        m_fault = 1; m_stop = 1;
      end
    end
  endtask

  task automatic run(input int n);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      if (q.size() == 0) gen();
      e = q.pop_front();
      check("addr", 32'(instr_addr), 32'(e.addr));
      check("ir", ir, e.ir);
      check("alu_en", 32'(alu_en), 32'(e.alu_en));
      check("alu_op", 32'(alu_op), 32'(e.alu_op));
      check("rf_we", 32'(rf_we), 32'(e.rf_we));
      check("rf_wsel", 32'(rf_wsel), 32'(e.rf_wsel));
      check("dmem_req", 32'(dmem_req), 32'(e.req));
      check("dmem_we", 32'(dmem_we), 32'(e.we));
      check("busy", 32'(busy), 32'(e.busy));
      check("halted", 32'(halted), 32'(e.halted));
      check("fault", 32'(fault), 32'(e.fault));
      if (dmem_req) req_cnt++;
      if (rf_we) rfwe_cnt++;
      start = e.start_v;
      alu_zero = e.zero_v;
      dmem_ack = e.ack_v;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    check("rst_addr", 32'(instr_addr), 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_flags", 32'({halted, fault, alu_en, rf_we}), 32'd0);
    rst_n = 1'b1;
    m_pc = '0; m_ir = '0; m_halted = 0; m_fault = 0; m_idle = 1; m_stop = 0;
    q.delete();
    req_cnt = 0; rfwe_cnt = 0;
  endtask

  task automatic directed(input bit fs, input int fl, input int fz);
    for (int i = 0; i < 64; i++) imem[i] = NOP;
    force_start = fs; force_lat = fl; force_zero = fz;
  endtask

  initial begin
    directed(1, 0, -1);
    // ALU, NOP, HALT with start held high
    imem[0] = 32'h1000_0000; imem[1] = NOP; imem[2] = 32'hF000_0000;
    do_reset();
    run(9);
    check("a_halted", 32'(halted), 32'd1);
    check("a_pc", 32'(instr_addr), 32'd3);
    check("a_rfwe_cnt", 32'(rfwe_cnt), 32'd1);
    run(3);

    // JMP to top of memory, NOP wraps pc
    directed(1, 0, -1);
    imem[0] = 32'hA000_003F;
    do_reset();
    run(3);
    check("jmp_pc63", 32'(instr_addr), 32'd63);
    run(2);
    check("jmp_wrap", 32'(instr_addr), 32'd0);

    // LOAD acked on third MEM cycle
    directed(1, 3, -1);
    imem[0] = 32'h8100_0000;
    do_reset();
    run(8);
    check("ld_req_cycles", 32'(req_cnt), 32'd3);
    check("ld_next_pc", 32'(instr_addr), 32'd1);

    // BEQZ taken then not taken
    directed(1, 0, 1);
    imem[0] = 32'hB000_0010;
    do_reset();
    run(5);
    check("beqz_taken", 32'(instr_addr), 32'h10);
    directed(1, 0, 0);
    imem[0] = 32'hB000_0010;
    do_reset();
    run(5);
    check("beqz_fall", 32'(instr_addr), 32'd1);

    // STORE never acked: timeout, STOP ignores start
    directed(1, 99, -1);
    imem[0] = 32'h9000_0000;
    do_reset();
    run(24);
    check("st_req_cycles", 32'(req_cnt), 32'd15);
    check("st_fault", 32'(fault), 32'd1);

    // Illegal opcode
    directed(1, 0, -1);
    imem[0] = 32'hC000_0000;
    do_reset();
    run(4);
    check("ill_fault", 32'(fault), 32'd1);

    // Reset asserted in the middle of a memory wait
    directed(1, 99, -1);
    imem[0] = 32'hA000_0005; imem[5] = 32'h8000_0000;
    do_reset();
    run(7);
    check("mid_req_before", 32'(dmem_req), 32'd1);
    check("mid_pc_before", 32'(instr_addr), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    check("mid_req_after", 32'(dmem_req), 32'd0);
    check("mid_pc_after", 32'(instr_addr), 32'd0);
    check("mid_busy_after", 32'(busy), 32'd0);

    // Random programs
    for (int r = 0; r < 8; r++) begin
      directed(0, 0, -1);
      for (int i = 0; i < 64; i++) begin
        int sel;
        logic [3:0] op;
        sel = $urandom_range(0, 19);
        if (sel < 6 || sel == 19) op = 4'($urandom_range(0, 7));
        else if (sel < 8) op = 4'h8;
        else if (sel < 10) op = 4'h9;
        else if (sel < 12) op = 4'hA;
        else if (sel < 14) op = 4'hB;
        else if (sel < 16) op = 4'hE;
        else if (sel < 18) op = 4'hF;
        else op = rb() ? 4'hC : 4'hD;
        imem[i] = {op, 28'($urandom)};
      end
      do_reset();
      run(400);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multicycle control sequencer for the Harvard core: owns the program counter, fetches 32-bit instructions from the instruction memory, and steps each through FETCH/DECODE/EXECUTE/MEM/WRITEBACK. It drives the ALU enable and opcode, the register-file write strobe, and a req/ack handshake to data memory. It replaces the free-running up-counter as the PC source, so branches, loads and halts sequence correctly.

## Interface
- PC_W, 6, program counter / instruction address width
- INSTR_W, 32, instruction width
- MEM_TIMEOUT, 15, max cycles waiting for dmem_ack before fault
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; one clock, all state in the clk domain
- start  in  1  level-sampled; launches execution from IDLE
- instr_addr  out  PC_W  instruction memory address (= pc)
- instr_data  in  INSTR_W  instruction memory read data (combinational read)
- ir  out  INSTR_W  latched instruction register
- alu_en  out  1  one-cycle ALU execute strobe
- alu_op  out  4  ir[31:28] when alu_en, else 0
- alu_zero  in  1  ALU result-zero flag, valid in the cycle after alu_en
- rf_we  out  1  one-cycle register-file write strobe
- rf_wsel  out  1  write source: 0 = ALU, 1 = data memory
- dmem_req  out  1  data memory request, held until ack
- dmem_we  out  1  qualifies dmem_req: 1 = store
- dmem_ack  in  1  data memory completion
- busy  out  1  high in any state except IDLE
- halted  out  1  sticky: HALT executed
- fault  out  1  sticky: illegal opcode or memory timeout

## Operation
- Instruction fields: opcode ir[31:28], rd ir[27:24], rs1 ir[23:20], rs2 ir[19:16], imm ir[15:0]; target = imm[PC_W-1:0].
- Opcodes: 0x0–0x7 ALU; 0x8 LOAD; 0x9 STORE; 0xA JMP; 0xB BEQZ; 0xE NOP; 0xF HALT; 0xC/0xD illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, STOP.
- IDLE: start=1 -> FETCH; clears halted. fault is cleared only by reset.
- FETCH: ir <= instr_data at the clock edge -> DECODE.
- DECODE:
  - ALU/LOAD/STORE/BEQZ -> EXEC.
  - JMP: pc <= target -> FETCH.
  - NOP: pc <= pc+1 -> FETCH.
  - HALT: halted <= 1, pc <= pc+1 -> IDLE.
  - Illegal: fault <= 1 -> STOP.
- EXEC: alu_en=1 for one cycle. ALU -> WB. LOAD/STORE -> MEM. BEQZ -> WB (no write; branch resolved in WB).
- MEM: dmem_req=1, dmem_we=(STORE). Wait counter increments each cycle.
  - dmem_ack=1: LOAD -> WB; STORE -> pc <= pc+1 -> FETCH.
  - Counter reaches MEM_TIMEOUT with no ack: fault <= 1 -> STOP.
- WB:
  - ALU: rf_we=1, rf_wsel=0, pc <= pc+1.
  - LOAD: rf_we=1, rf_wsel=1, pc <= pc+1.
  - BEQZ: pc <= alu_zero ? target : pc+1; rf_we=0.
  - All cases -> FETCH.
- STOP: terminal until reset; all strobes 0.
- PC arithmetic is modulo 2^PC_W: 63+1 wraps to 0 without a flag.

## Timing
- Reset values: pc=0, ir=0, state=IDLE; all outputs 0 (instr_addr=0).
- Reset asserted mid-operation (including MEM with dmem_req high) drops every output to its reset value immediately. No pending request survives reset.
- Cycles per instruction, counted from FETCH entry to the next FETCH entry:
  - ALU 4; LOAD 4+n; STORE 3+n, where n ≥ 1 is the number of MEM cycles including the ack cycle.
  - JMP 2; NOP 2; BEQZ 4.
  - HALT: 2 cycles to IDLE.
- instr_addr changes only on pc updates; it is stable throughout FETCH.
- dmem_ack is sampled only in MEM and ignored elsewhere. Ack in the first MEM cycle gives n=1.
- dmem_ack in the same cycle the counter hits MEM_TIMEOUT: ack wins.
- start held high: HALT returns to IDLE, then re-launches on the next cycle at pc+1.

## Structure
- Shared package cpu_pkg: opcode constants, state enum, field-position constants, PC_W/INSTR_W defaults.
- One sub-module, seq_mem_timer: loadable wait counter with a timeout compare, cleared on MEM entry.
- Everything else stays in cpu_sequencer: FSM, pc, ir.

## Test plan
- Reset release, start=1, imem = ALU 0x1, NOP, HALT -> rf_we pulses once, in cycle 4; halted=1 after 8 cycles; final pc=3.
- JMP target=0x3F, then NOP at 0x3F -> pc reaches 63, then wraps to 0.
- LOAD with dmem_ack after 3 cycles -> dmem_req high exactly 3 cycles, then rf_we=1 with rf_wsel=1; instruction totals 7 cycles.
- BEQZ target=0x10, run twice: alu_zero=1 -> pc=0x10; alu_zero=0 -> pc=pc+1.
- STORE with no ack -> dmem_req high for MEM_TIMEOUT cycles, fault=1, state STOP; start ignored afterwards.
- Opcode 0xC -> fault=1 after DECODE; assert reset mid-MEM on a separate run -> dmem_req=0 immediately, pc=0.
